// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshake on both sides.
// Single-cycle logic ops, bit-serial shifts, optional shift-add multiply.
//
// Optional feature macro: ALU_SEQ_MUL_EN (opcode E = unsigned multiply).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (ready only in IDLE)
//   A, B, Sel             operands and opcode, captured on accept
//   out_valid / out_ready result handshake
//   Y                     result
//   carry, overflow,      status flags, registered together with Y
//   zero, negative, illegal
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH:0]   m_sum;
    logic [WIDTH-1:0] st_hi;
`endif

    logic             accept;
    logic             exec_last;
    logic [SHW-1:0]   n;

    // single-cycle result
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] s_y;
    logic             s_c;
    logic             s_v;
    logic             s_ill;
    logic             s_multi;

    // one EXEC step
    logic [WIDTH-1:0] st_acc;
    logic             st_out;
    logic             fin_c;

    assign n         = B[SHW-1:0];
    assign accept    = in_valid && in_ready;
    assign exec_last = (state == EXEC) && (cnt_q == CW'(1));

    always_comb begin
        add_w   = {1'b0, A} + {1'b0, B};
        sub_w   = {1'b0, A} - {1'b0, B};
        s_y     = '0;
        s_c     = 1'b0;
        s_v     = 1'b0;
        s_ill   = 1'b0;
        s_multi = 1'b0;
        unique case (Sel)
            4'h0: begin
                s_y = add_w[WIDTH-1:0];
                s_c = add_w[WIDTH];
                s_v = (A[WIDTH-1] == B[WIDTH-1]) &&
                      (add_w[WIDTH-1] != A[WIDTH-1]);
            end
            4'h1: begin
                // borrow bit of the widened difference is A < B
                s_y = sub_w[WIDTH-1:0];
                s_c = sub_w[WIDTH];
                s_v = (A[WIDTH-1] != B[WIDTH-1]) &&
                      (sub_w[WIDTH-1] != A[WIDTH-1]);
            end
            4'h2: s_y = A & B;
            4'h3: s_y = A | B;
            4'h4: s_y = A ^ B;
            4'h5: s_y = ~(A & B);
            4'h6: s_y = ~(A | B);
            4'h7: s_y = ~(A ^ B);
            4'h8: s_y = ~A;
            4'h9: begin
                s_y = A << 1;
                s_c = A[WIDTH-1];
            end
            4'hA: begin
                s_y = A >> 1;
                s_c = A[0];
            end
            4'hB, 4'hC, 4'hD: begin
                // zero shift amount completes at once
                if (n == '0) begin
                    s_y = A;
                end else begin
                    s_multi = 1'b1;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            4'hE: s_multi = 1'b1;
`endif
            default: s_ill = 1'b1;
        endcase
    end

    always_comb begin
        st_acc = acc_q;
        st_out = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        m_sum = {1'b0, hi_q} +
                (acc_q[0] ? {1'b0, mcand_q} : '0);
        st_hi = m_sum[WIDTH:1];
`endif
        unique case (op_q)
            4'hB: begin
                st_acc = acc_q << 1;
                st_out = acc_q[WIDTH-1];
            end
            4'hC: begin
                st_acc = acc_q >> 1;
                st_out = acc_q[0];
            end
            4'hD: begin
                st_acc = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                st_out = acc_q[0];
            end
`ifdef ALU_SEQ_MUL_EN
            4'hE: begin
                // product shifts right through {hi, acc};
                // acc starts as the multiplier
                st_acc = {m_sum[0], acc_q[WIDTH-1:1]};
            end
`endif
            default: st_acc = acc_q;
        endcase
        fin_c = st_out;
`ifdef ALU_SEQ_MUL_EN
        if (op_q == 4'hE) begin
            fin_c = |st_hi;
        end
`endif
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = s_multi ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (cnt_q == CW'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            Y        <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            illegal  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand_q  <= '0;
            hi_q     <= '0;
`endif
        end else if (accept) begin
            op_q  <= Sel;
            acc_q <= A;
            cnt_q <= {1'b0, n};
`ifdef ALU_SEQ_MUL_EN
            if (Sel == 4'hE) begin
                acc_q   <= B;
                mcand_q <= A;
                hi_q    <= '0;
                cnt_q   <= CW'(WIDTH);
            end
`endif
            if (!s_multi) begin
                Y        <= s_y;
                carry    <= s_c;
                overflow <= s_v;
                zero     <= (s_y == '0);
                negative <= s_y[WIDTH-1];
                illegal  <= s_ill;
            end
        end else if (state == EXEC) begin
            acc_q <= st_acc;
            cnt_q <= cnt_q - CW'(1);
`ifdef ALU_SEQ_MUL_EN
            hi_q  <= st_hi;
`endif
            if (exec_last) begin
                Y        <= st_acc;
                carry    <= fin_c;
                overflow <= 1'b0;
                zero     <= (st_acc == '0);
                negative <= st_acc[WIDTH-1];
                illegal  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq at WIDTH=4
// against an integer-arithmetic reference model.
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Sel;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] Y;
    logic       carry;
    logic       overflow;
    logic       zero;
    logic       negative;
    logic       illegal;

    int total;
    int bad;

    alu_seq #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .Sel      (Sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Y        (Y),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .negative (negative),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, got, exp);
        end
    endtask

    // reference: plain integer arithmetic on 4-bit values
    task automatic model(input int a, input int b, input int sel,
                         output int y, output int c, output int v,
                         output int il, output int lat);
        int sa, sb, s, n, r;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        n = b % 4;
        y = 0; c = 0; v = 0; il = 0; lat = 0;
        case (sel)
            0: begin
                r = a + b; y = r % 16; c = int'(r > 15);
                s = sa + sb; v = int'(s > 7 || s < -8);
            end
            1: begin
                r = a - b; y = (r + 16) % 16; c = int'(a < b);
                s = sa - sb; v = int'(s > 7 || s < -8);
            end
            2: y = a & b;
            3: y = a | b;
            4: y = a ^ b;
            5: y = 15 - (a & b);
            6: y = 15 - (a | b);
            7: y = 15 - (a ^ b);
            8: y = 15 - a;
            9: begin y = (a * 2) % 16; c = int'(a >= 8); end
            10: begin y = a / 2; c = a % 2; end
            11: begin
                y = (a << n) % 16; lat = n;
                c = (n != 0) ? (a >> (4 - n)) & 1 : 0;
            end
            12: begin
                y = a >> n; lat = n;
                c = (n != 0) ? (a >> (n - 1)) & 1 : 0;
            end
            13: begin
                y = (sa >>> n) & 15; lat = n;
                c = (n != 0) ? (sa >>> (n - 1)) & 1 : 0;
            end
`ifdef ALU_SEQ_MUL_EN
            14: begin
                r = a * b; y = r % 16; c = int'(r > 15); lat = 4;
            end
`endif
            default: il = 1;
        endcase
    endtask

    task automatic run_op(input int a, input int b, input int sel,
                          input int hold, input bit poke);
        int y, c, v, il, lat;
        model(a, b, sel, y, c, v, il, lat);
        @(negedge clk);
        chk("idle_ready", in_ready, 1);
        A = 4'(a); B = 4'(b); Sel = 4'(sel);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = 4'($urandom); B = 4'($urandom); Sel = 4'($urandom);
        for (int i = 0; i < lat; i++) begin
            chk("busy_valid", out_valid, 0);
            chk("busy_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        chk("done_valid", out_valid, 1);
        chk("y", Y, y);
        chk("carry", carry, c);
        chk("ovf", overflow, v);
        chk("zero", zero, int'(y == 0));
        chk("neg", negative, int'(y >= 8));
        chk("illegal", illegal, il);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                in_valid = 1'b1;
                A = 4'($urandom); B = 4'($urandom);
                Sel = 4'($urandom);
            end
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", in_ready, 0);
            chk("hold_y", Y, y);
            chk("hold_c", carry, c);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("hs_valid", out_valid, 0);
        chk("hs_ready", in_ready, 1);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0; B = '0; Sel = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_y", Y, 0);
        chk("rst_flags",
            {carry, overflow, zero, negative, illegal}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", in_ready, 1);

        run_op(6, 11, 0, 0, 0);
        run_op(6, 11, 1, 1, 0);
        run_op(6, 11, 11, 0, 0);
        run_op(6, 8, 11, 0, 0);
        run_op(8, 2, 13, 0, 0);
        run_op(8, 2, 12, 0, 0);
        run_op(6, 11, 14, 0, 0);
        run_op(6, 11, 15, 0, 0);
        run_op(9, 3, 9, 0, 0);
        run_op(9, 3, 10, 0, 0);
        run_op(3, 5, 2, 5, 1);

        // abort a 3-step shift with reset
        @(negedge clk);
        A = 4'd6; B = 4'd11; Sel = 4'd11;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_abort", out_valid, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_y", Y, 0);
        chk("abort_flags",
            {carry, overflow, zero, negative, illegal}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("no_result", out_valid, 0);
        end
        run_op(6, 11, 11, 0, 0);

        for (int k = 0; k < 80; k++) begin
            run_op(int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 2)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
